// File: rtl/cell3_bist_pkg.sv
// ---------------------------------------------------------------------------
// cell3_bist_pkg
// Shared definitions for the 3-input cell BIST controller and its golden
// reference model: FSM state encoding, cell-select encodings and the
// exhaustive vector count for a 3-input cell.
// ---------------------------------------------------------------------------
package cell3_bist_pkg;

    // Controller FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    // Cell-under-test select encodings
    localparam logic [1:0] SEL_AND3  = 2'd0;
    localparam logic [1:0] SEL_NAND3 = 2'd1;
    localparam logic [1:0] SEL_NOR3  = 2'd2;
    localparam logic [1:0] SEL_RSVD  = 2'd3;

    // Exhaustive stimulus for three inputs
    localparam int NUM_VEC = 8;

    // Width of the settle counter and of the error counter
    localparam int CNT_W = 4;

    // A select value is runnable only if it names a real cell
    function automatic logic sel_is_legal(input logic [1:0] sel);
        return (sel != SEL_RSVD);
    endfunction

endpackage

// File: rtl/cell3_golden.sv
// ---------------------------------------------------------------------------
// cell3_golden
// Combinational expected-output model of the selectable 3-input cell.
//
// Ports:
//   SEL   in  [1:0]  cell select (AND3 / NAND3 / NOR3 / reserved)
//   A,B,C in         cell inputs
//   Y_EXP out        expected cell output; 0 for the reserved select
// ---------------------------------------------------------------------------
module cell3_golden (
    input  logic [1:0] SEL,
    input  logic       A,
    input  logic       B,
    input  logic       C,
    output logic       Y_EXP
);
    import cell3_bist_pkg::*;

    always_comb begin
        Y_EXP = 1'b0;
        case (SEL)
            SEL_AND3:  Y_EXP =   A & B & C;
            SEL_NAND3: Y_EXP = ~(A & B & C);
            SEL_NOR3:  Y_EXP = ~(A | B | C);
            default:   Y_EXP = 1'b0;
        endcase
    end

endmodule

// File: rtl/cell3_bist.sv
// ---------------------------------------------------------------------------
// cell3_bist
// Built-in self-test controller for a selectable 3-input logic cell. A run
// walks all eight input combinations in ascending order, holds each for
// SETTLE_CYC+1 cycles, samples the cell output on the last edge of that
// window and records mismatches against the golden model.
//
// Parameters:
//   SETTLE_CYC  cycles a vector settles before the sample cycle (1..15)
//
// Ports:
//   CLK        in        clock, rising edge
//   RST        in        synchronous active-high reset
//   START      in        run request, honoured in IDLE only
//   ABORT      in        terminate a run in progress
//   SEL        in  [1:0] cell select, latched when a run is accepted
//   A,B,C      out       registered stimulus to the cell (A is the MSB)
//   Y          in        cell output
//   BUSY       out       run in progress
//   DONE       out       one-cycle completion pulse
//   PASS       out       no mismatches in the completed run
//   FAIL_MASK  out [7:0] bit v set when vector v mismatched
//   ERR_CNT    out [3:0] number of mismatching vectors
// ---------------------------------------------------------------------------
module cell3_bist #(
    parameter int SETTLE_CYC = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic       ABORT,
    input  logic [1:0] SEL,
    output logic       A,
    output logic       B,
    output logic       C,
    input  logic       Y,
    output logic       BUSY,
    output logic       DONE,
    output logic       PASS,
    output logic [7:0] FAIL_MASK,
    output logic [3:0] ERR_CNT
);
    import cell3_bist_pkg::*;

    // SETTLE spends SETTLE_CYC cycles counting this value down to zero,
    // then SAMPLE adds the final cycle of the window.
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [2:0]       LAST_VEC    = 3'(NUM_VEC - 1);
    localparam logic [3:0]       ERR_MAX     = 4'(NUM_VEC);

    // Registered state
    state_t           r_state;
    logic [2:0]       r_vec;
    logic [CNT_W-1:0] r_settle;
    logic [1:0]       r_sel;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [7:0]       r_fail_mask;
    logic [3:0]       r_err_cnt;

    // Combinational control
    state_t     w_next;
    logic       w_accept;
    logic       w_abort;
    logic       w_sample;
    logic       w_last;
    logic       w_y_exp;
    logic       w_mismatch;
    logic [3:0] w_err_next;

    // Golden expected value for the vector currently on A/B/C
    cell3_golden u_golden (
        .SEL   (r_sel),
        .A     (r_vec[2]),
        .B     (r_vec[1]),
        .C     (r_vec[0]),
        .Y_EXP (w_y_exp)
    );

    assign w_mismatch = (Y != w_y_exp);
    assign w_err_next = !w_mismatch            ? r_err_cnt :
                        (r_err_cnt == ERR_MAX) ? r_err_cnt :
                                                 r_err_cnt + 4'd1;

    // FSM state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next state and per-cycle control strobes
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_abort  = 1'b0;
        w_sample = 1'b0;
        w_last   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // ABORT alongside START suppresses the run
                if (START && !ABORT && sel_is_legal(SEL)) begin
                    w_next   = ST_SETTLE;
                    w_accept = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (ABORT) begin
                    w_next  = ST_IDLE;
                    w_abort = 1'b1;
                end else if (r_settle == '0) begin
                    w_next = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (ABORT) begin
                    w_next  = ST_IDLE;
                    w_abort = 1'b1;
                end else begin
                    w_sample = 1'b1;
                    if (r_vec == LAST_VEC) begin
                        w_next = ST_FINISH;
                        w_last = 1'b1;
                    end else begin
                        w_next = ST_SETTLE;
                    end
                end
            end
            ST_FINISH: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Stimulus, counters and result registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_vec       <= '0;
            r_settle    <= '0;
            r_sel       <= SEL_AND3;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail_mask <= '0;
            r_err_cnt   <= '0;
        end else begin
            // DONE is high exactly for the FINISH cycle
            r_done <= w_last;

            if (w_accept) begin
                r_sel       <= SEL;
                r_vec       <= '0;
                r_settle    <= SETTLE_LOAD;
                r_busy      <= 1'b1;
                r_pass      <= 1'b0;
                r_fail_mask <= '0;
                r_err_cnt   <= '0;
            end else if (w_abort) begin
                // Partial FAIL_MASK / ERR_CNT are left visible
                r_vec    <= '0;
                r_settle <= '0;
                r_busy   <= 1'b0;
                r_pass   <= 1'b0;
            end else if (w_sample) begin
                if (w_mismatch) begin
                    r_fail_mask[r_vec] <= 1'b1;
                end
                r_err_cnt <= w_err_next;
                if (w_last) begin
                    // Include the final vector's result in the verdict
                    r_vec    <= '0;
                    r_settle <= '0;
                    r_busy   <= 1'b0;
                    r_pass   <= (w_err_next == 4'd0);
                end else begin
                    r_vec    <= r_vec + 3'd1;
                    r_settle <= SETTLE_LOAD;
                end
            end else if (r_state == ST_SETTLE && r_settle != '0) begin
                r_settle <= r_settle - 1'b1;
            end
        end
    end

    assign A         = r_vec[2];
    assign B         = r_vec[1];
    assign C         = r_vec[0];
    assign BUSY      = r_busy;
    assign DONE      = r_done;
    assign PASS      = r_pass;
    assign FAIL_MASK = r_fail_mask;
    assign ERR_CNT   = r_err_cnt;

endmodule

// File: tb/tb_cell3_bist.sv
// ---------------------------------------------------------------------------
// tb_cell3_bist
// Self-checking bench for cell3_bist: a table of complete runs against
// several cell behaviours, followed by hand-written sequences for abort,
// reset, illegal select and START/ABORT interactions.
// ---------------------------------------------------------------------------
module tb_cell3_bist;
    import cell3_bist_pkg::*;

    localparam int S   = 4;
    localparam int WIN = S + 1;
    localparam int RUN = 8 * WIN;

    // Cell behaviours connected to Y
    localparam int M_AND3   = 0;
    localparam int M_STUCK0 = 1;
    localparam int M_STUCK1 = 2;
    localparam int M_OR3    = 3;
    localparam int M_GOLDEN = 4;

    logic       CLK = 1'b0;
    logic       RST, START, ABORT;
    logic [1:0] SEL;
    logic       A, B, C, Y;
    logic       BUSY, DONE, PASS;
    logic [7:0] FAIL_MASK;
    logic [3:0] ERR_CNT;

    int         cell_mode;
    logic [1:0] cell_sel;
    logic       w_ref;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    cell3_bist #(.SETTLE_CYC(S)) dut (
        .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .SEL(SEL),
        .A(A), .B(B), .C(C), .Y(Y),
        .BUSY(BUSY), .DONE(DONE), .PASS(PASS),
        .FAIL_MASK(FAIL_MASK), .ERR_CNT(ERR_CNT)
    );

    // A correct cell of the selected type, used as one of the cell behaviours
    cell3_golden u_ref (.SEL(cell_sel), .A(A), .B(B), .C(C), .Y_EXP(w_ref));

    always_comb begin
        Y = 1'b0;
        case (cell_mode)
            M_AND3:   Y = A & B & C;
            M_STUCK0: Y = 1'b0;
            M_STUCK1: Y = 1'b1;
            M_OR3:    Y = A | B | C;
            default:  Y = w_ref;
        endcase
    end

    typedef struct {
        logic [1:0] sel;
        int         mode;
        logic [7:0] mask;
        logic [3:0] err;
        logic       pass;
    } run_vec_t;

    run_vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Returns just after the accepting edge E0
    task automatic start_run(input logic [1:0] sel);
        SEL   = sel;
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    // Called at E0+t0; follows the run to DONE and checks the outcome
    task automatic finish_run(input int t0, input string tag, input logic [7:0] em,
                              input logic [3:0] ee, input logic ep);
        int t       = t0;
        int done_at = -1;
        bit seq_ok  = 1'b1;
        while (done_at < 0 && t < RUN + 20) begin
            if (t < RUN) begin
                if ({A, B, C} !== 3'(t / WIN) || BUSY !== 1'b1 || DONE !== 1'b0)
                    seq_ok = 1'b0;
            end
            tick();
            t++;
            if (DONE === 1'b1) done_at = t;
        end
        check({tag, "_vec_seq"}, 32'(seq_ok), 32'd1);
        check({tag, "_done_at"}, done_at, RUN);
        check({tag, "_pass"}, 32'(PASS), 32'(ep));
        check({tag, "_mask"}, 32'(FAIL_MASK), 32'(em));
        check({tag, "_err"}, 32'(ERR_CNT), 32'(ee));
        check({tag, "_busy_fin"}, 32'(BUSY), 32'd0);
        tick();
        check({tag, "_done_pulse"}, 32'(DONE), 32'd0);
        check({tag, "_abc_idle"}, 32'({A, B, C}), 32'd0);
        check({tag, "_pass_hold"}, 32'(PASS), 32'(ep));
    endtask

    // Watches n cycles; both BUSY and DONE must stay low and A/B/C at 0
    task automatic expect_quiet(input string tag, input int n);
        bit ok = 1'b1;
        for (int k = 0; k < n; k++) begin
            tick();
            if (BUSY !== 1'b0 || DONE !== 1'b0 || {A, B, C} !== 3'd0) ok = 1'b0;
        end
        check({tag, "_quiet"}, 32'(ok), 32'd1);
    endtask

    initial begin
        tbl[0] = '{sel: SEL_AND3,  mode: M_AND3,   mask: 8'h00, err: 4'd0, pass: 1'b1};
        tbl[1] = '{sel: SEL_NAND3, mode: M_AND3,   mask: 8'hFF, err: 4'd8, pass: 1'b0};
        tbl[2] = '{sel: SEL_NOR3,  mode: M_STUCK0, mask: 8'h01, err: 4'd1, pass: 1'b0};
        tbl[3] = '{sel: SEL_NAND3, mode: M_GOLDEN, mask: 8'h00, err: 4'd0, pass: 1'b1};
        tbl[4] = '{sel: SEL_NOR3,  mode: M_GOLDEN, mask: 8'h00, err: 4'd0, pass: 1'b1};
        tbl[5] = '{sel: SEL_AND3,  mode: M_STUCK1, mask: 8'h7F, err: 4'd7, pass: 1'b0};
        tbl[6] = '{sel: SEL_AND3,  mode: M_OR3,    mask: 8'h7E, err: 4'd6, pass: 1'b0};
        tbl[7] = '{sel: SEL_NOR3,  mode: M_AND3,   mask: 8'h81, err: 4'd2, pass: 1'b0};

        RST = 1'b1; START = 1'b0; ABORT = 1'b0; SEL = SEL_AND3;
        cell_mode = M_AND3; cell_sel = SEL_AND3;
        tick();
        tick();
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_done", 32'(DONE), 32'd0);
        check("rst_pass", 32'(PASS), 32'd0);
        check("rst_mask", 32'(FAIL_MASK), 32'd0);
        check("rst_err",  32'(ERR_CNT), 32'd0);
        check("rst_abc",  32'({A, B, C}), 32'd0);
        RST = 1'b0;
        tick();

        // Full runs against assorted cells
        for (int i = 0; i < 8; i++) begin
            cell_mode = tbl[i].mode;
            cell_sel  = tbl[i].sel;
            start_run(tbl[i].sel);
            finish_run(0, $sformatf("tbl%0d", i), tbl[i].mask, tbl[i].err, tbl[i].pass);
            tick();
        end

        // ABORT after edge E0+10: vectors 0 and 1 already sampled against stuck-1
        cell_mode = M_STUCK1;
        start_run(SEL_AND3);
        repeat (10) tick();
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        check("abort_busy", 32'(BUSY), 32'd0);
        check("abort_abc",  32'({A, B, C}), 32'd0);
        check("abort_pass", 32'(PASS), 32'd0);
        check("abort_done", 32'(DONE), 32'd0);
        check("abort_mask", 32'(FAIL_MASK), 32'h03);
        check("abort_err",  32'(ERR_CNT), 32'd2);
        expect_quiet("abort", RUN + 10);
        check("abort_mask_hold", 32'(FAIL_MASK), 32'h03);

        // A fresh run after abort goes the full distance
        cell_mode = M_AND3;
        start_run(SEL_AND3);
        finish_run(0, "post_abort", 8'h00, 4'd0, 1'b1);

        // SEL=3 START is ignored: PASS from the previous run stays set
        SEL   = SEL_RSVD;
        START = 1'b1;
        tick();
        START = 1'b0;
        check("sel3_busy", 32'(BUSY), 32'd0);
        check("sel3_pass", 32'(PASS), 32'd1);
        expect_quiet("sel3", 10);
        check("sel3_pass_hold", 32'(PASS), 32'd1);

        // ABORT in IDLE has no effect on the held result
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        check("idle_abort_pass", 32'(PASS), 32'd1);

        // Reset at edge E0+21 of a failing run
        cell_mode = M_STUCK1;
        start_run(SEL_AND3);
        repeat (20) tick();
        check("pre_rst_err", 32'(ERR_CNT), 32'd4);
        RST   = 1'b1;
        START = 1'b1;
        ABORT = 1'b1;
        tick();
        RST   = 1'b0;
        START = 1'b0;
        ABORT = 1'b0;
        check("midrst_outputs", 32'({BUSY, DONE, PASS, A, B, C, FAIL_MASK, ERR_CNT}), 32'd0);
        expect_quiet("midrst", RUN + 10);

        // START re-pulsed mid-run with a new SEL: no restart, latched SEL kept
        cell_mode = M_AND3;
        start_run(SEL_AND3);
        repeat (15) tick();
        SEL   = SEL_NAND3;
        START = 1'b1;
        tick();
        START = 1'b0;
        finish_run(16, "repulse", 8'h00, 4'd0, 1'b1);

        // START and ABORT together in IDLE: stays idle, PASS untouched
        SEL   = SEL_AND3;
        START = 1'b1;
        ABORT = 1'b1;
        tick();
        START = 1'b0;
        ABORT = 1'b0;
        check("start_abort_busy", 32'(BUSY), 32'd0);
        check("start_abort_pass", 32'(PASS), 32'd1);
        expect_quiet("start_abort", 10);

        // Normal run timing afterwards
        cell_mode = M_STUCK0;
        start_run(SEL_NOR3);
        finish_run(0, "final", 8'h01, 4'd1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cell3_bist.md
CELL3_BIST -- requirements
Module: cell3_bist

Interface
REQ-001 The block SHALL have parameter SETTLE_CYC, default 4: cycles each vector is held before Y is sampled; legal range 1..15.
REQ-002 The block SHALL have port CLK, input, 1: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RST, input, 1: reset, synchronous and active-high.
REQ-004 The block SHALL have port START, input, 1: request a test run; sampled in IDLE only.
REQ-005 The block SHALL have port ABORT, input, 1: terminate a run in progress.
REQ-006 The block SHALL have port SEL, input, 2: cell under test; 0=AND3, 1=NAND3, 2=NOR3, 3=reserved.
REQ-007 The block SHALL have ports A, B, C, output, 1 each: registered stimulus driven into the 3-input cell under test.
REQ-008 The block SHALL have port Y, input, 1: cell output, sampled by the checker.
REQ-009 The block SHALL have port BUSY, output, 1: high while a run is in progress.
REQ-010 The block SHALL have port DONE, output, 1: one-cycle pulse on run completion.
REQ-011 The block SHALL have port PASS, output, 1: valid while DONE=1 and until the next START; 1 iff ERR_CNT=0.
REQ-012 The block SHALL have port FAIL_MASK, output, 8: bit v set iff vector v mismatched.
REQ-013 The block SHALL have port ERR_CNT, output, 4: number of mismatching vectors (0..8).

Function
REQ-014 The block SHALL use FSM states IDLE, SETTLE, SAMPLE and FINISH.
- IDLE->SETTLE on START=1 with SEL!=3.
- SETTLE->SAMPLE when the settle counter reaches 0.
- SAMPLE->SETTLE for vectors 0..6; SAMPLE->FINISH for vector 7.
- FINISH->IDLE unconditionally.
REQ-015 The block SHALL encode vector v (0..7) as A=v[2], B=v[1], C=v[0], applied in ascending order starting at v=0.
REQ-016 The block SHALL latch SEL on the accepting START edge; SEL changes during a run SHALL have no effect.
REQ-017 The block SHALL hold each vector for exactly SETTLE_CYC+1 cycles and sample Y on the last edge of that window; the same edge loads vector v+1.
REQ-018 The block SHALL compute the expected value from the latched SEL: AND3=A&B&C, NAND3=~(A&B&C), NOR3=~(A|B|C).
REQ-019 On a mismatch the block SHALL set FAIL_MASK[v] and increment ERR_CNT by 1; ERR_CNT SHALL NOT wrap (maximum 8).
REQ-020 On the accepting START edge the block SHALL clear FAIL_MASK, ERR_CNT and PASS, and SHALL set BUSY=1.
REQ-021 The block SHALL assert DONE=1, BUSY=0 for exactly one cycle in FINISH, which occurs after edge E0+8*(SETTLE_CYC+1), where E0 is the accepting START edge; after FINISH, A, B and C SHALL be 0.
REQ-022 START while BUSY=1 SHALL be ignored; START with SEL=3 SHALL be ignored with no state change.
REQ-023 ABORT=1 while BUSY=1 SHALL force IDLE on the next edge with BUSY=0, A=B=C=0, no DONE and PASS=0; FAIL_MASK and ERR_CNT SHALL hold their partial values.
REQ-024 START and ABORT both high in IDLE SHALL leave the block in IDLE (ABORT wins).
REQ-025 ABORT in IDLE or FINISH SHALL have no effect.

Reset
REQ-026 RST=1 at any edge, including mid-run, SHALL force IDLE, A=B=C=0, BUSY=0, DONE=0, PASS=0, FAIL_MASK=0, ERR_CNT=0 and clear the vector and settle counters.
REQ-027 RST SHALL take priority over START and ABORT.

Structure
REQ-028 A shared package cell3_bist_pkg SHALL hold the FSM state enum, the SEL encodings (SEL_AND3, SEL_NAND3, SEL_NOR3) and the vector count constant 8.
REQ-029 The expected-value logic SHALL be one combinational sub-module, cell3_golden (inputs SEL, A, B, C; output Y_EXP), reused by the bench as its reference model.

Verification
REQ-030 SEL=0, correct AND3 connected, SETTLE_CYC=4, START pulse -> DONE high 40 cycles after the START edge, PASS=1, FAIL_MASK=8'h00, ERR_CNT=0.
REQ-031 SEL=1 with an AND3 connected (inverted cell) -> PASS=0, FAIL_MASK=8'hFF, ERR_CNT=8.
REQ-032 SEL=2 with Y stuck at 0 -> FAIL_MASK=8'h01, ERR_CNT=1, PASS=0.
REQ-033 SEL=0, ABORT at cycle 10 of the run -> BUSY=0 next cycle, A=B=C=0, DONE never pulses; a following START runs the full sequence.
REQ-034 RST asserted at cycle 20 of a run, and START with SEL=3 -> all outputs return to their reset values, no DONE; the SEL=3 START leaves BUSY at 0.
REQ-035 START re-pulsed while BUSY=1, and START and ABORT together in IDLE -> no restart, and the run timing is unchanged.
